// File: rtl/branch_target_table_if.sv
// rtl/branch_target_table_if.sv - read/write/clear bus of the branch target table
//
// Groups every non-clock, non-reset signal of branch_target_table.
//   slave  : the table itself (read/write/clear requests in, read data and clear status out)
//   master : the requester driving the table
// Signals:
//   RdEn, RdBank, LutPointer   read request, bank and entry
//   Target, Hit, RdValid       registered read response
//   WrEn, WrBank, WrPtr, WrData write request
//   ClrReq, ClrBank            bank-invalidate request
//   Busy, ClrDone              clear in progress / one-cycle completion pulse
interface branch_target_table_if #(
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 4,
    parameter int BANK_W = 2
);
    logic              RdEn;
    logic [BANK_W-1:0] RdBank;
    logic [PTR_W-1:0]  LutPointer;
    logic [ADDR_W-1:0] Target;
    logic              Hit;
    logic              RdValid;
    logic              WrEn;
    logic [BANK_W-1:0] WrBank;
    logic [PTR_W-1:0]  WrPtr;
    logic [ADDR_W-1:0] WrData;
    logic              ClrReq;
    logic [BANK_W-1:0] ClrBank;
    logic              Busy;
    logic              ClrDone;

    modport slave (
        input  RdEn, RdBank, LutPointer,
        input  WrEn, WrBank, WrPtr, WrData,
        input  ClrReq, ClrBank,
        output Target, Hit, RdValid, Busy, ClrDone
    );

    modport master (
        output RdEn, RdBank, LutPointer,
        output WrEn, WrBank, WrPtr, WrData,
        output ClrReq, ClrBank,
        input  Target, Hit, RdValid, Busy, ClrDone
    );
endinterface

// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - banked branch target table with per-bank clear sequencer
//
// One bank of 2**PTR_W absolute branch targets per program, 2**BANK_W banks.
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous active-high reset (valid bits, outputs, clear FSM)
//   bus    branch_target_table_if.slave: one-cycle-latency read with write
//          bypass, single-entry write, and a bank clear that walks every
//          entry of the chosen bank, one per cycle, while Busy is high.
module branch_target_table #(
    parameter int ADDR_W = 10,
    parameter int PTR_W  = 4,
    parameter int BANK_W = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    branch_target_table_if.slave  bus
);
    localparam int NB    = 1 << BANK_W;
    localparam int NE    = 1 << PTR_W;
    localparam int N     = NB * NE;
    localparam int IDX_W = BANK_W + PTR_W;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    // Data array carries no reset; the valid bits alone decide a hit.
    logic [ADDR_W-1:0] mem_q [N];
    logic [N-1:0]      valid_q, valid_d;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  cnt_q, cnt_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              hit_q, hit_d;
    logic              rdvalid_q, rdvalid_d;

    logic              busy;
    logic              wr_fire;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    assign busy    = (state_q == CLEAR);
    assign wr_fire = bus.WrEn && !busy;
    assign wr_idx  = {bus.WrBank, bus.WrPtr};
    assign rd_idx  = {bus.RdBank, bus.LutPointer};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bank_d    = bank_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        target_d  = target_q;
        hit_d     = hit_q;
        rdvalid_d = bus.RdEn;

        case (state_q)
            IDLE: begin
                // A write alongside a clear request lands first; the clear
                // then sweeps over it if it targets the same bank.
                if (wr_fire) begin
                    valid_d[wr_idx] = 1'b1;
                end
                if (bus.ClrReq) begin
                    state_d = CLEAR;
                    bank_d  = bus.ClrBank;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                valid_d[{bank_q, cnt_q}] = 1'b0;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.RdEn) begin
            if (busy && (bus.RdBank == bank_q)) begin
                // The bank under clear is treated as empty for its whole sweep.
                target_d = '0;
                hit_d    = 1'b0;
            end else if (wr_fire && (wr_idx == rd_idx)) begin
                target_d = bus.WrData;
                hit_d    = 1'b1;
            end else if (valid_q[rd_idx]) begin
                target_d = mem_q[rd_idx];
                hit_d    = 1'b1;
            end else begin
                target_d = '0;
                hit_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bank_q    <= '0;
            done_q    <= 1'b0;
            valid_q   <= '0;
            target_q  <= '0;
            hit_q     <= 1'b0;
            rdvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bank_q    <= bank_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            target_q  <= target_d;
            hit_q     <= hit_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_fire) begin
            mem_q[wr_idx] <= bus.WrData;
        end
    end

    assign bus.Target  = target_q;
    assign bus.Hit     = hit_q;
    assign bus.RdValid = rdvalid_q;
    assign bus.Busy    = busy;
    assign bus.ClrDone = done_q;
endmodule

// File: tb/tb_branch_target_table.sv
// tb/tb_branch_target_table.sv - self-checking bench for branch_target_table
module tb_branch_target_table;
    localparam int ADDR_W = 10;
    localparam int PTR_W  = 4;
    localparam int BANK_W = 2;
    localparam int NB     = 1 << BANK_W;
    localparam int NE     = 1 << PTR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_target_table_if #(.ADDR_W(ADDR_W), .PTR_W(PTR_W), .BANK_W(BANK_W)) bus ();

    branch_target_table #(.ADDR_W(ADDR_W), .PTR_W(PTR_W), .BANK_W(BANK_W)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // Reference model: a table of entries plus "how many entries of the
    // clear are still to go".
    bit              m_valid [NB][NE];
    int              m_data  [NB][NE];
    int              clear_left;
    int              clr_bank_m;
    int              exp_target;
    int              exp_hit;
    int              exp_rdvalid;
    int              exp_done;
    int              done_count;
    int              busy_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".Target"},  32'(bus.Target),  32'(exp_target));
        chk({tag, ".Hit"},     32'(bus.Hit),     32'(exp_hit));
        chk({tag, ".RdValid"}, 32'(bus.RdValid), 32'(exp_rdvalid));
        chk({tag, ".Busy"},    32'(bus.Busy),    32'(clear_left > 0));
        chk({tag, ".ClrDone"}, 32'(bus.ClrDone), 32'(exp_done));
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < NE; p++)
                m_valid[b][p] = 1'b0;
        clear_left  = 0;
        exp_target  = 0;
        exp_hit     = 0;
        exp_rdvalid = 0;
        exp_done    = 0;
    endtask

    // One clock with the given requests, then compare every output to the model.
    task automatic cycle(input string tag, input int rd, input int rb, input int rp,
                         input int wr, input int wb, input int wp, input int wd,
                         input int clr, input int cb);
        bit busy_pre;
        bus.RdEn       = rd[0];
        bus.RdBank     = BANK_W'(rb);
        bus.LutPointer = PTR_W'(rp);
        bus.WrEn       = wr[0];
        bus.WrBank     = BANK_W'(wb);
        bus.WrPtr      = PTR_W'(wp);
        bus.WrData     = ADDR_W'(wd);
        bus.ClrReq     = clr[0];
        bus.ClrBank    = BANK_W'(cb);

        busy_pre    = (clear_left > 0);
        exp_rdvalid = rd;
        if (rd != 0) begin
            if (busy_pre && rb == clr_bank_m) begin
                exp_target = 0; exp_hit = 0;
            end else if (wr != 0 && !busy_pre && wb == rb && wp == rp) begin
                exp_target = wd; exp_hit = 1;
            end else if (m_valid[rb][rp]) begin
                exp_target = m_data[rb][rp]; exp_hit = 1;
            end else begin
                exp_target = 0; exp_hit = 0;
            end
        end
        exp_done = (busy_pre && clear_left == 1) ? 1 : 0;

        @(posedge clk);
        #1;
        if (busy_pre) begin
            m_valid[clr_bank_m][NE - clear_left] = 1'b0;
            clear_left--;
        end else begin
            if (wr != 0) begin
                m_valid[wb][wp] = 1'b1;
                m_data[wb][wp]  = wd;
            end
            if (clr != 0) begin
                clr_bank_m = cb;
                clear_left = NE;
            end
        end
        if (bus.ClrDone === 1'b1) done_count++;
        if (bus.Busy === 1'b1) busy_count++;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd_only(input string tag, input int rb, input int rp);
        cycle(tag, 1, rb, rp, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr_only(input string tag, input int wb, input int wp, input int wd);
        cycle(tag, 0, 0, 0, 1, wb, wp, wd, 0, 0);
    endtask

    // Runs until the clear finishes plus one cycle for ClrDone; bounded.
    task automatic wait_clear(input string tag);
        int n = 0;
        while (clear_left > 0 && n < 40) begin
            cycle(tag, $urandom_range(0, 1), $urandom_range(0, NB - 1), $urandom_range(0, NE - 1),
                  0, 0, 0, 0, 0, 0);
            n++;
        end
        chk({tag, ".bounded"}, 32'(clear_left), 32'd0);
        idle({tag, ".done"});
    endtask

    initial begin
        bus.RdEn = 0; bus.RdBank = 0; bus.LutPointer = 0;
        bus.WrEn = 0; bus.WrBank = 0; bus.WrPtr = 0; bus.WrData = 0;
        bus.ClrReq = 0; bus.ClrBank = 0;
        model_reset();
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < NE; p++)
                m_data[b][p] = 0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst = 1'b0;

        // Reset state reads as a miss.
        rd_only("rd_after_reset", 0, 3);

        // Plain write then reads.
        wr_only("wr_b1p0", 1, 0, 14);
        rd_only("rd_b1p0", 1, 0);
        rd_only("rd_b0p0", 0, 0);
        idle("hold");

        // Same-cycle write/read bypass.
        cycle("bypass", 1, 2, 5, 1, 2, 5, 100, 0, 0);
        rd_only("rd_b2p5", 2, 5);

        // Fill bank 1 and bank 0, clear bank 1.
        for (int p = 0; p < NE; p++) wr_only("fill_b1", 1, p, $urandom_range(0, 1023));
        for (int p = 0; p < NE; p++) wr_only("fill_b0", 0, p, $urandom_range(0, 1023));
        done_count = 0;
        busy_count = 0;
        cycle("clr_b1", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        wait_clear("clr_b1_run");
        chk("clr_b1.busy_cycles", 32'(busy_count), 32'(NE));
        chk("clr_b1.done_pulses", 32'(done_count), 32'd1);
        for (int p = 0; p < NE; p++) rd_only("rd_b1_cleared", 1, p);
        for (int p = 0; p < NE; p++) rd_only("rd_b0_intact", 0, p);

        // Write and clear requests during Busy are ignored.
        done_count = 0;
        cycle("clr_b0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle("clr_b0_w1");
        cycle("busy_wr", 0, 0, 0, 1, 0, 2, 44, 0, 0);
        cycle("busy_clr", 0, 0, 0, 0, 0, 0, 0, 1, 3);
        cycle("busy_rd_other", 1, 2, 5, 0, 0, 0, 0, 0, 0);
        cycle("busy_rd_same", 1, 0, 15, 0, 0, 0, 0, 0, 0);
        wait_clear("clr_b0_run");
        repeat (NE + 2) idle("after_clr_b0");
        chk("clr_b0.done_pulses", 32'(done_count), 32'd1);
        rd_only("rd_b0p2", 0, 2);

        // Write and clear together in IDLE: write first, then swept away.
        cycle("wr_and_clr", 0, 0, 0, 1, 3, 4, 77, 1, 3);
        wait_clear("clr_b3_run");
        rd_only("rd_b3p4", 3, 4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rand", $urandom_range(0, 1), $urandom_range(0, NB - 1), $urandom_range(0, NE - 1),
                  $urandom_range(0, 1), $urandom_range(0, NB - 1), $urandom_range(0, NE - 1),
                  $urandom_range(0, 1023), ($urandom_range(0, 19) == 0) ? 1 : 0,
                  $urandom_range(0, NB - 1));
        end
        wait_clear("rand_drain");

        // Reset at clear counter 7 aborts the sweep.
        for (int b = 0; b < NB; b++) wr_only("prefill", b, 9, 300 + b);
        done_count = 0;
        cycle("clr_b2", 0, 0, 0, 0, 0, 0, 0, 1, 2);
        repeat (7) idle("clr_b2_run");
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_clear_reset");
        #1;
        rst = 1'b0;
        for (int b = 0; b < NB; b++)
            for (int p = 0; p < NE; p++)
                rd_only("rd_after_abort", b, p);
        chk("abort.done_pulses", 32'(done_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
